simple_mac: RTL and testbench

SIMPLE_MAC -- requirements
Module: simple_mac

---
 rtl/simple_mac_pkg.sv | 16 +
 rtl/mac_acc_reg.sv | 22 ++
 rtl/simple_mac.sv | 68 ++++++
 tb/tb_simple_mac.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/simple_mac_pkg.sv
// Shared widths and accumulator type for the simple_mac multiply-accumulate slice.
// Saturating arithmetic is enabled by defining SIMPLE_MAC_SAT_EN at build time.
package simple_mac_pkg;

    localparam int DATA_W_DEF  = 16;
    localparam int GUARD_W_DEF = 8;

    function automatic int acc_w(input int data_w, input int guard_w);
        return 2 * data_w + guard_w;
    endfunction

    localparam int ACC_W_DEF = acc_w(DATA_W_DEF, GUARD_W_DEF);

    typedef logic signed [ACC_W_DEF-1:0] acc_t;

endpackage

// File: rtl/mac_acc_reg.sv
// Accumulator register: asynchronous reset to zero, loads d when load is high.
module mac_acc_reg #(
    parameter int W = simple_mac_pkg::ACC_W_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic signed [W-1:0] d,
    output logic signed [W-1:0] q
);

    // NOTE: sequential state uses non-blocking assignment so every register
    // samples pre-edge values, which gives read-modify-write its 1-cycle latency.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/simple_mac.sv
// Signed multiply-accumulate with two accumulator registers and a combinational adder.
// Define SIMPLE_MAC_SAT_EN to saturate res instead of wrapping modulo 2^ACC_W.
module simple_mac
    import simple_mac_pkg::*;
#(
    parameter  int DATA_W  = DATA_W_DEF,
    parameter  int GUARD_W = GUARD_W_DEF,
    localparam int ACC_W   = acc_w(DATA_W, GUARD_W)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic signed [DATA_W-1:0] opa,
    input  logic signed [DATA_W-1:0] opb,
    input  logic                     copa,
    input  logic                     csel,
    input  logic                     cw0,
    input  logic                     cw1,
    output logic signed [ACC_W-1:0]  res,
    output logic signed [ACC_W-1:0]  acr,
    output logic signed [ACC_W-1:0]  acr0,
    output logic signed [ACC_W-1:0]  acr1
);

    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]    prod_ext;
    logic signed [ACC_W-1:0]    add_b;

    assign prod     = opa * opb;
    assign prod_ext = {{GUARD_W{prod[2*DATA_W-1]}}, prod};
    assign acr      = csel ? acr0 : acr1;
    assign add_b    = copa ? acr : '0;

`ifdef SIMPLE_MAC_SAT_EN
    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    // One extra bit makes overflow visible as disagreement of the top two bits.
    logic signed [ACC_W:0] sum_wide;
    assign sum_wide = {add_b[ACC_W-1], add_b} + {prod_ext[ACC_W-1], prod_ext};

    // NOTE: res gets its default first so no path through this block infers a latch.
    always_comb begin
        res = sum_wide[ACC_W-1:0];
        if (sum_wide[ACC_W] != sum_wide[ACC_W-1]) begin
            res = sum_wide[ACC_W] ? ACC_MIN : ACC_MAX;
        end
    end
`else
    assign res = add_b + prod_ext;
`endif

    mac_acc_reg #(.W(ACC_W)) u_acr0 (
        .clk  (clk),
        .rst  (rst),
        .load (cw0),
        .d    (res),
        .q    (acr0)
    );

    mac_acc_reg #(.W(ACC_W)) u_acr1 (
        .clk  (clk),
        .rst  (rst),
        .load (cw1),
        .d    (res),
        .q    (acr1)
    );

endmodule

// File: tb/tb_simple_mac.sv
// Self-checking bench for simple_mac: directed cases plus random operations against
// an arithmetic model; honours SIMPLE_MAC_SAT_EN for the overflow expectation.
module tb_simple_mac;
    import simple_mac_pkg::*;

    localparam longint HALF = longint'(1) << 39;
    localparam longint FULL = longint'(1) << 40;

    logic              clk = 1'b0;
    logic              rst;
    logic signed [15:0] opa, opb;
    logic              copa, csel, cw0, cw1;
    acc_t              res, acr, acr0, acr1;

    int n_assert = 0;
    int n_fail   = 0;

    longint m_acr0, m_acr1;

    simple_mac dut (
        .clk  (clk),
        .rst  (rst),
        .opa  (opa),
        .opb  (opb),
        .copa (copa),
        .csel (csel),
        .cw0  (cw0),
        .cw1  (cw1),
        .res  (res),
        .acr  (acr),
        .acr0 (acr0),
        .acr1 (acr1)
    );

    always #5 clk = ~clk;

    // Bring an exact sum into the 40-bit signed range by the build's overflow rule.
    function automatic longint fit(input longint v);
        longint r;
`ifdef SIMPLE_MAC_SAT_EN
        if (v > HALF - 1) return HALF - 1;
        if (v < -HALF)    return -HALF;
        return v;
`else
        r = v % FULL;
        if (r < 0)     r += FULL;
        if (r >= HALF) r -= FULL;
        return r;
`endif
    endfunction

    function automatic longint model_acr();
        return csel ? m_acr0 : m_acr1;
    endfunction

    function automatic longint model_res();
        longint p = longint'(opa) * longint'(opb);
        return fit((copa ? model_acr() : 0) + p);
    endfunction

    task automatic check(input string tag, input acc_t obs, input longint exp);
        acc_t e;
        e = exp[39:0];
        n_assert++;
        assert (obs === e) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, e);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".res"},  res,  model_res());
        check({tag, ".acr"},  acr,  model_acr());
        check({tag, ".acr0"}, acr0, m_acr0);
        check({tag, ".acr1"}, acr1, m_acr1);
    endtask

    task automatic set_in(input int a, input int b, input logic c_opa, input logic c_sel,
                          input logic w0, input logic w1);
        opa  = 16'(a);
        opb  = 16'(b);
        copa = c_opa;
        csel = c_sel;
        cw0  = w0;
        cw1  = w1;
    endtask

    // Inputs are held across the edge, so the model result is computed just before it.
    task automatic tick();
        longint r = model_res();
        @(posedge clk);
        #1;
        if (cw0) m_acr0 = r;
        if (cw1) m_acr1 = r;
    endtask

    task automatic reset_pulse();
        rst = 1'b1;
        #1;
        m_acr0 = 0;
        m_acr1 = 0;
        check_all("rst_pulse");
        rst = 1'b0;
    endtask

    initial begin
        m_acr0 = 0;
        m_acr1 = 0;
        rst = 1'b1;
        set_in(3, 4, 1'b1, 1'b0, 1'b1, 1'b1);
        #12;
        check("reset.acr0", acr0, 0);
        check("reset.acr1", acr1, 0);
        check("reset.acr",  acr,  0);
        check("reset.res",  res,  12);
        rst = 1'b0;

        tick();
        check("post_reset_write.acr0", acr0, 12);
        check("post_reset_write.acr1", acr1, 12);

        #2;
        reset_pulse();
        check("rst_mid.acr0", acr0, 0);

        set_in(3, 4, 1'b0, 1'b0, 1'b1, 1'b0);
        #1;
        check("load12.res", res, 12);
        tick();
        check("load12.acr0", acr0, 12);
        check("load12.acr1", acr1, 0);

        set_in(-2, 5, 1'b1, 1'b1, 1'b1, 1'b0);
        #1;
        check("acc_csel1.res", res, 2);
        tick();
        check("acc_csel1.acr0", acr0, 2);

        set_in(3, 4, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        set_in(-2, 5, 1'b1, 1'b0, 1'b1, 1'b0);
        tick();
        check("acc_csel0.acr0", acr0, -10);

        set_in(7, 6, 1'b0, 1'b0, 1'b1, 1'b1);
        tick();
        check("dual.acr0", acr0, 42);
        check("dual.acr1", acr1, 42);
        csel = 1'b0;
        #1;
        check("dual.acr_sel0", acr, 42);
        csel = 1'b1;
        #1;
        check("dual.acr_sel1", acr, 42);

        set_in(-32768, 32767, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        check("minmax.res", res, -1073709056);
        n_assert++;
        assert (res[39:30] === 10'h3FF) else begin
            n_fail++;
            $error("FAIL minmax.upper: observed %h expected 3ff", res[39:30]);
        end

        set_in(0, 0, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        check("ovf_clear.acr0", acr0, 0);
        set_in(-32768, -32768, 1'b1, 1'b1, 1'b1, 1'b0);
        repeat (511) tick();
        check("ovf_511.acr0", acr0, HALF - (longint'(1) << 30));
        tick();
`ifdef SIMPLE_MAC_SAT_EN
        check("ovf_512.acr0", acr0, HALF - 1);
`else
        check("ovf_512.acr0", acr0, -HALF);
`endif
        check_all("ovf_model");

        for (int i = 0; i < 300; i++) begin
            set_in(int'($urandom_range(0, 65535)) - 32768,
                   ($urandom_range(0, 3) == 0) ? -32768 : int'($urandom_range(0, 65535)) - 32768,
                   1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            if ($urandom_range(0, 15) == 0) reset_pulse();
            #1;
            check_all("rand_pre");
            tick();
            check_all("rand_post");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
